eff_echo: RTL
=============

Name: eff_echo

Overview:
- Delay-line echo stage inside the effects pipe.
- Sits between the I2S receive sample stream and the next effect or transmit stage, running on the mclk domain.
- Stores past samples in a circular buffer and adds a gain-scaled delayed sample to each incoming sample.
- Uses the same data/valid sample interface as the other eff_pipe stages; there is no backpressure.

Parameters:
- DATA_W, 24, signed sample width in two's complement.
- ADDR_W, 12, buffer address width; DEPTH = 2**ADDR_W samples.
- GAIN_W, 8, unsigned gain width in Q0.GAIN_W format.

Ports:
- clk  in  1  sample-domain clock (mclk).
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = echo applied; 0 = bypass (dry passthrough).
- delay  in  ADDR_W  echo delay in samples.
- gain  in  GAIN_W  wet gain; value g scales by g/2**GAIN_W.
- data_i  in  DATA_W  input sample.
- vld_i  in  1  single-cycle strobe, data_i valid.
- data_o  out  DATA_W  output sample.
- vld_o  out  1  single-cycle strobe, data_o valid.
- busy  out  1  high while the buffer is clearing or a sample is in flight.
- overrun  out  1  sticky flag: a vld_i was dropped.

Behaviour:
- Reset values:
  - data_o=0, vld_o=0, overrun=0, busy=1.
  - wr_ptr=0; state=CLEAR.
  - Buffer RAM is not reset and is cleared by the CLEAR sweep.
- State machine states: CLEAR, IDLE, RD, MIX, OUT.
- CLEAR:
  - Writes 0 to address clr_ptr on each cycle, incrementing clr_ptr from 0 to DEPTH-1.
  - After DEPTH cycles, moves to IDLE and wr_ptr is 0.
  - Any vld_i during CLEAR is dropped and sets overrun.
- IDLE, vld_i=1:
  - Registers x=data_i and the current en, delay and gain.
  - Issues a RAM read at rd_addr=(wr_ptr-delay) mod DEPTH, then goes to RD.
- RD: RAM data d becomes valid (synchronous read, 1 cycle); go to MIX.
- MIX:
  - p = d*gain, a signed product of DATA_W+GAIN_W+1 bits.
  - w = p >>> GAIN_W (arithmetic shift).
  - y = saturate(x + w) to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
  - Go to OUT.
- OUT:
  - data_o = y if the captured en=1, else x; vld_o=1 for exactly this one cycle.
  - Writes RAM[wr_ptr] = x (see Optional Feature).
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - Returns to IDLE.
- Latency: vld_i in cycle N gives vld_o in cycle N+3. The next accepted vld_i is in cycle N+4 or later.
- vld_i while state is not IDLE: the sample is dropped and overrun is set. overrun clears only on reset.
- busy = (state != IDLE).
- Delay range:
  - delay=k with 1<=k<=DEPTH-1 mixes the sample accepted k samples earlier.
  - delay=0 reads the slot about to be overwritten, which gives a full DEPTH-sample delay.
- Control sampling: en, delay and gain are sampled only at acceptance. Changes mid-sample do not affect the sample in flight.
- Bypass: with en=0, the buffer is still written with the dry sample, so enabling echo plays existing history immediately.
- Reset mid-operation: all state returns asynchronously to the reset values and the CLEAR sweep restarts from 0. There is no partial output.

Optional Feature:
- Macro: ECHO_FEEDBACK_EN.
- Defined: OUT writes y instead of x to RAM[wr_ptr], giving a regenerative multi-tap echo. This applies only when the captured en=1; in bypass x is still written.
- Undefined: only x is written, giving a single echo repeat.
- Latency and interface are identical in both builds.

Test Plan:
1. Reset, then hold rst_n=1 with ADDR_W=4 -> busy=1 for 16 cycles then 0; vld_i at CLEAR cycle 5 -> sample dropped, overrun=1.
2. ADDR_W=4, en=1, delay=2, gain=128; feed 100, 0, 0, 0 -> data_o = 100, 0, 50, 0; each vld_o exactly 3 cycles after its vld_i.
3. en=0, same stream -> data_o equals data_i exactly; then set en=1, delay=4, gain=255 with inputs 0 -> the echo of the earlier 100 appears as 99 (bypass history retained).
4. Saturation: history 8388000 at delay=1, gain=255, input 8388000 -> data_o=8388607; negative mirror with -8388000 -> -8388608.
5. Back-to-back vld_i on consecutive cycles -> second sample dropped, overrun sticky, first output correct; assert rst_n=0 mid-RD -> vld_o never pulses and CLEAR restarts.
6. ECHO_FEEDBACK_EN defined, delay=1, gain=128, impulse 1000 then zeros -> 1000, 500, 250, 125; undefined -> 1000, 500, 0, 0.

Source files
------------

// File: rtl/eff_echo.sv
// Delay-line echo stage for the effects pipe (mclk domain).
// Keeps a circular buffer of past samples and adds a gain-scaled delayed sample
// to each incoming sample, saturating to the sample range.
// Optional build macro: ECHO_FEEDBACK_EN -- when defined, the mixed (wet) sample
// is written back into the buffer for regenerative multi-tap echo; otherwise
// only the dry sample is stored (single repeat).
module eff_echo #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned GAIN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] delay,
    input  logic [GAIN_W-1:0] gain,
    input  logic [DATA_W-1:0] data_i,
    input  logic              vld_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned P_W   = DATA_W + GAIN_W + 1;
    localparam int unsigned S_W   = DATA_W + 2;

    localparam logic signed [S_W-1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [S_W-1:0] SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_RD,
        S_MIX,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] rd_q;
    logic              en_q;
    logic [GAIN_W-1:0] gain_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept_c;
    logic              drop_c;
    logic              ram_we_c;
    logic [ADDR_W-1:0] ram_waddr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] wdata_c;
    logic [ADDR_W-1:0] rd_addr_c;

    logic signed [P_W-1:0] d_ext_c;
    logic signed [P_W-1:0] g_ext_c;
    logic signed [P_W-1:0] prod_c;
    logic signed [S_W-1:0] wet_c;
    logic signed [S_W-1:0] sum_c;
    logic [DATA_W-1:0]     y_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and RAM port control
    always_comb begin
        state_nxt   = state;
        accept_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_waddr_c = wr_ptr;
        ram_wdata_c = '0;
        drop_c      = vld_i && (state != S_IDLE);
        case (state)
            S_CLEAR: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = clr_ptr;
                if (&clr_ptr) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (vld_i) begin
                    accept_c  = 1'b1;
                    state_nxt = S_RD;
                end
            end
            S_RD:  state_nxt = S_MIX;
            S_MIX: state_nxt = S_OUT;
            S_OUT: begin
                ram_we_c    = 1'b1;
                ram_wdata_c = wdata_c;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Read address: delay 0 lands on the slot about to be overwritten (full-depth delay)
    assign rd_addr_c = wr_ptr - delay;

    // Buffer write-back value; data_o holds the wet sample during OUT when echo is on
    always_comb begin
`ifdef ECHO_FEEDBACK_EN
        wdata_c = en_q ? data_o : x_q;
`else
        wdata_c = x_q;
`endif
    end

    // Gain multiply, arithmetic scale-down and saturating mix
    always_comb begin
        d_ext_c = {{(P_W-DATA_W){rd_q[DATA_W-1]}}, rd_q};
        g_ext_c = {{(P_W-GAIN_W){1'b0}}, gain_q};
        prod_c  = d_ext_c * g_ext_c;
        wet_c   = S_W'(prod_c >>> GAIN_W);
        sum_c   = {{2{x_q[DATA_W-1]}}, x_q} + wet_c;
        if (sum_c > SAT_MAX) begin
            y_c = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sum_c < SAT_MIN) begin
            y_c = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            y_c = DATA_W'(sum_c);
        end
    end

    // Pointers, captured sample/controls and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            clr_ptr <= '0;
            x_q     <= '0;
            en_q    <= 1'b0;
            gain_q  <= '0;
            data_o  <= '0;
            vld_o   <= 1'b0;
            busy    <= 1'b1;
            overrun <= 1'b0;
        end else begin
            vld_o <= (state == S_MIX);
            busy  <= (state_nxt != S_IDLE);
            if (drop_c) begin
                overrun <= 1'b1;
            end
            if (state == S_CLEAR) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
            if (accept_c) begin
                x_q    <= data_i;
                en_q   <= en;
                gain_q <= gain;
            end
            if (state == S_MIX) begin
                data_o <= en_q ? y_c : x_q;
            end
            if (state == S_OUT) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
        end
    end

    // Sample buffer: single write port, synchronous read issued at acceptance
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            mem[ram_waddr_c] <= ram_wdata_c;
        end
        if (accept_c) begin
            rd_q <= mem[rd_addr_c];
        end
    end

endmodule
